// File: rtl/dot_accum_if.sv
// Valid/ready bus for dot_accum: product stream in, dot-product sum out.
// The slave side is the accumulator; the master side feeds it and drains it.
interface dot_accum_if #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_ovf,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_ovf,
        output out_ready
    );
endinterface

// File: rtl/dot_accum.sv
// Accumulates LEN unsigned products into one sum, then holds it on a
// valid/ready output until the consumer takes it.
module dot_accum #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 16,
    parameter int LEN   = 4
) (
    input logic         clk,
    input logic         rst,
    dot_accum_if.slave  bus
);
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic [ACC_W-1:0] sum_q;
    logic             ovf_q;

    logic             in_fire;
    logic             out_fire;
    logic             last;
    logic [ACC_W:0]   sum_ext;
    logic             carry;

    // Handshake flags come straight from state so in_ready never sees out_ready.
    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = sum_q;
    assign bus.out_ovf   = ovf_q;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;
    assign last     = (cnt == CNT_LAST);

    assign sum_ext = {1'b0, acc} + {1'b0, ACC_W'(bus.in_data)};
    assign carry   = sum_ext[ACC_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            unique case (state)
                ACC: begin
                    // in_data is only looked at on a real transfer.
                    if (in_fire) begin
                        if (last) begin
                            sum_q <= sum_ext[ACC_W-1:0];
                            ovf_q <= ovf | carry;
                            acc   <= '0;
                            cnt   <= '0;
                            ovf   <= 1'b0;
                            state <= HOLD;
                        end else begin
                            acc <= sum_ext[ACC_W-1:0];
                            cnt <= cnt + CNT_ONE;
                            ovf <= ovf | carry;
                        end
                    end
                end
                HOLD: begin
                    if (out_fire) begin
                        state <= ACC;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dot_accum.sv
// Directed bench for dot_accum: default build (LEN=4, ACC_W=16) and a
// narrow build (LEN=8, ACC_W=10) that wraps.
module tb_dot_accum;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    dot_accum_if #(.IN_W(8), .ACC_W(16)) b0 ();
    dot_accum_if #(.IN_W(8), .ACC_W(10)) b1 ();

    dot_accum #(.IN_W(8), .ACC_W(16), .LEN(4)) u0 (
        .clk(clk),
        .rst(rst),
        .bus(b0)
    );

    dot_accum #(.IN_W(8), .ACC_W(10), .LEN(8)) u1 (
        .clk(clk),
        .rst(rst),
        .bus(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are read there too.
    task automatic drive0(input logic v, input logic [7:0] d);
        b0.in_valid = v;
        b0.in_data  = d;
        @(negedge clk);
    endtask

    task automatic drive1(input logic v, input logic [7:0] d);
        b1.in_valid = v;
        b1.in_data  = d;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        b0.in_valid = 1'b0; b0.in_data = 8'h00; b0.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_data = 8'h00; b1.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (b0.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready0: got %b want 1", b0.in_ready); end
        vectors++; if (b0.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid0: got %b want 0", b0.out_valid); end
        vectors++; if (b0.out_sum !== 16'd0) begin miscompares++; $display("FAIL reset_out_sum0: got %0d want 0", b0.out_sum); end
        vectors++; if (b0.out_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_out_ovf0: got %b want 0", b0.out_ovf); end
        vectors++; if (b1.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready1: got %b want 1", b1.in_ready); end
        vectors++; if (b1.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid1: got %b want 0", b1.out_valid); end
        vectors++; if (b1.out_sum !== 10'd0) begin miscompares++; $display("FAIL reset_out_sum1: got %0d want 0", b1.out_sum); end
    endtask

    task automatic test_back_to_back;
        b0.out_ready = 1'b1;
        drive0(1'b1, 8'd15);
        drive0(1'b1, 8'd30);
        drive0(1'b1, 8'd45);
        vectors++; if (b0.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_early_valid: got %b want 0", b0.out_valid); end
        drive0(1'b1, 8'd60);
        vectors++; if (b0.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid: got %b want 1", b0.out_valid); end
        vectors++; if (b0.in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_in_ready_hold: got %b want 0", b0.in_ready); end
        vectors++; if (b0.out_sum !== 16'd150) begin miscompares++; $display("FAIL b2b_sum1: got %0d want 150", b0.out_sum); end
        vectors++; if (b0.out_ovf !== 1'b0) begin miscompares++; $display("FAIL b2b_ovf1: got %b want 0", b0.out_ovf); end
        drive0(1'b0, 8'hxx);
        vectors++; if (b0.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_one_cycle: got %b want 0", b0.out_valid); end
        vectors++; if (b0.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready_back: got %b want 1", b0.in_ready); end
        for (int i = 0; i < 4; i++) drive0(1'b1, 8'd225);
        vectors++; if (b0.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid2: got %b want 1", b0.out_valid); end
        vectors++; if (b0.out_sum !== 16'd900) begin miscompares++; $display("FAIL b2b_sum2: got %0d want 900", b0.out_sum); end
        drive0(1'b0, 8'hxx);
    endtask

    task automatic test_gaps;
        b0.out_ready = 1'b1;
        drive0(1'b1, 8'd1);
        drive0(1'b0, 8'hxx);
        drive0(1'b1, 8'd2);
        drive0(1'b0, 8'hxx);
        drive0(1'b0, 8'hxx);
        drive0(1'b1, 8'd3);
        vectors++; if (b0.out_valid !== 1'b0) begin miscompares++; $display("FAIL gaps_early_valid: got %b want 0", b0.out_valid); end
        drive0(1'b1, 8'd4);
        vectors++; if (b0.out_valid !== 1'b1) begin miscompares++; $display("FAIL gaps_valid: got %b want 1", b0.out_valid); end
        vectors++; if (b0.out_sum !== 16'd10) begin miscompares++; $display("FAIL gaps_sum: got %0d want 10", b0.out_sum); end
        drive0(1'b0, 8'hxx);
        vectors++; if (b0.out_valid !== 1'b0) begin miscompares++; $display("FAIL gaps_one_cycle: got %b want 0", b0.out_valid); end
    endtask

    task automatic test_backpressure;
        b0.out_ready = 1'b0;
        drive0(1'b1, 8'd5);
        drive0(1'b1, 8'd6);
        drive0(1'b1, 8'd7);
        drive0(1'b1, 8'd8);
        for (int i = 0; i < 5; i++) begin
            drive0(1'b1, 8'd100);
            vectors++; if (b0.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_held[%0d]: got %b want 1", i, b0.out_valid); end
            vectors++; if (b0.out_sum !== 16'd26) begin miscompares++; $display("FAIL bp_sum_stable[%0d]: got %0d want 26", i, b0.out_sum); end
            vectors++; if (b0.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, b0.in_ready); end
        end
        b0.out_ready = 1'b1;
        drive0(1'b0, 8'hxx);
        vectors++; if (b0.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %b want 0", b0.out_valid); end
        for (int i = 0; i < 4; i++) drive0(1'b1, 8'd2);
        vectors++; if (b0.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_next_valid: got %b want 1", b0.out_valid); end
        vectors++; if (b0.out_sum !== 16'd8) begin miscompares++; $display("FAIL bp_next_sum: got %0d want 8", b0.out_sum); end
        drive0(1'b0, 8'hxx);
    endtask

    task automatic test_wrap;
        b1.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) drive1(1'b1, 8'd225);
        vectors++; if (b1.out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_early_valid: got %b want 0", b1.out_valid); end
        drive1(1'b1, 8'd225);
        vectors++; if (b1.out_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_valid: got %b want 1", b1.out_valid); end
        vectors++; if (b1.out_sum !== 10'd776) begin miscompares++; $display("FAIL wrap_sum: got %0d want 776", b1.out_sum); end
        vectors++; if (b1.out_ovf !== 1'b1) begin miscompares++; $display("FAIL wrap_ovf: got %b want 1", b1.out_ovf); end
        drive1(1'b0, 8'hxx);
        for (int i = 0; i < 8; i++) drive1(1'b1, 8'd1);
        vectors++; if (b1.out_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_next_valid: got %b want 1", b1.out_valid); end
        vectors++; if (b1.out_sum !== 10'd8) begin miscompares++; $display("FAIL wrap_next_sum: got %0d want 8", b1.out_sum); end
        vectors++; if (b1.out_ovf !== 1'b0) begin miscompares++; $display("FAIL wrap_next_ovf: got %b want 0", b1.out_ovf); end
        drive1(1'b0, 8'hxx);
    endtask

    task automatic test_reset_mid;
        b0.out_ready = 1'b1;
        drive0(1'b1, 8'd7);
        drive0(1'b1, 8'd9);
        rst = 1'b1;
        drive0(1'b0, 8'hxx);
        rst = 1'b0;
        vectors++; if (b0.in_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_in_ready: got %b want 1", b0.in_ready); end
        vectors++; if (b0.out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_out_valid: got %b want 0", b0.out_valid); end
        b0.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive0(1'b1, 8'd1);
        vectors++; if (b0.out_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_valid: got %b want 1", b0.out_valid); end
        vectors++; if (b0.out_sum !== 16'd4) begin miscompares++; $display("FAIL rmid_sum: got %0d want 4", b0.out_sum); end
        rst = 1'b1;
        drive0(1'b0, 8'hxx);
        rst = 1'b0;
        vectors++; if (b0.out_valid !== 1'b0) begin miscompares++; $display("FAIL rhold_valid: got %b want 0", b0.out_valid); end
        vectors++; if (b0.out_sum !== 16'd0) begin miscompares++; $display("FAIL rhold_sum: got %0d want 0", b0.out_sum); end
        vectors++; if (b0.in_ready !== 1'b1) begin miscompares++; $display("FAIL rhold_in_ready: got %b want 1", b0.in_ready); end
        b0.out_ready = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
